image_streamer: RTL and testbench

Transmit-side companion of the convolution windower. Collects one image of 2^LOG2_IMG_SIZE samples, one sample per handshake, from an upstream ready/valid source into an on-chip frame buffer. It then replays the image as a gap-free burst of THROUGHPUT samples per cycle, which is the contiguous-frame contract the windower's vld_in/data_in input requires. It sits between the I/Q sample ingest and the first convolution layer.

---
 rtl/radio_stream_pkg.sv | 34 +++
 rtl/frame_bank.sv | 32 +++
 rtl/image_streamer.sv | 156 +++++++++++++++
 tb/tb_image_streamer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/radio_stream_pkg.sv
// Shared types and constant helpers for the radio sample streaming blocks.
package radio_stream_pkg;

    // Frame streamer control states
    typedef enum logic [1:0] {
        S_FILL,
        S_PRIME,
        S_STREAM,
        S_GAP
    } stream_state_t;

    // Output words per image
    function automatic int calc_words(input int log2_img, input int tp);
        return (1 << log2_img) / tp;
    endfunction

    // Read counter width; kept at least 1 bit so a single-word image still has an address
    function automatic int calc_rd_w(input int log2_img, input int tp);
        int w;
        w = log2_img - $clog2(tp);
        return (w < 1) ? 1 : w;
    endfunction

    // Gap counter width
    function automatic int calc_gap_w(input int gap);
        return $clog2(gap + 1);
    endfunction

    // Lane that sample n lands in; the oldest sample of a word takes the highest lane
    function automatic int lane_of(input int n, input int tp);
        return tp - 1 - (n % tp);
    endfunction

endpackage

// File: rtl/frame_bank.sv
// Simple dual-port frame buffer: one write port, one synchronous read port
// with single-cycle latency. The read register resets so the streamer's
// output is zero after reset; the array itself is never cleared.
module frame_bank #(
    parameter int DW    = 2,
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    // Array write
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Registered read; holds its value while re is low
    always_ff @(posedge clk or posedge rst) begin
        if (rst)     rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/image_streamer.sv
// Collects one image of 2^LOG2_IMG_SIZE samples through a ready/valid port,
// then replays it as a gap-free burst of THROUGHPUT samples per cycle for the
// convolution windower, followed by at least GAP idle cycles.
// Optional build macro IMG_STREAMER_PINGPONG_EN: two banks, so the next image
// is accepted while the previous one streams.
module image_streamer
    import radio_stream_pkg::*;
#(
    parameter int NO_CH         = 2,
    parameter int LOG2_IMG_SIZE = 10,
    parameter int THROUGHPUT    = 1,
    parameter int GAP           = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 s_vld,
    output logic                                 s_rdy,
    input  logic [NO_CH-1:0]                     s_data,
    output logic                                 vld_out,
    output logic [THROUGHPUT-1:0][NO_CH-1:0]     data_out,
    output logic                                 frame_done
);

    localparam int WORDS   = calc_words(LOG2_IMG_SIZE, THROUGHPUT);
    localparam int LOG2_TP = $clog2(THROUGHPUT);
    localparam int RW      = calc_rd_w(LOG2_IMG_SIZE, THROUGHPUT);
    localparam int GW      = calc_gap_w(GAP);
    localparam int LW      = (LOG2_TP < 1) ? 1 : LOG2_TP;
    localparam int DW      = THROUGHPUT * NO_CH;

    stream_state_t state, nxt;

    logic [LOG2_IMG_SIZE-1:0]           wr_cnt;
    logic [RW-1:0]                      rd_cnt, raddr, waddr;
    logic [GW-1:0]                      gap_cnt;
    logic [THROUGHPUT-1:0][NO_CH-1:0]   pack, pack_nxt;
    logic [LW-1:0]                      lane;
    logic hs, last_hs, we, re, rd_last, gap_end, frame_rdy;

    assign hs      = s_vld && s_rdy;
    assign last_hs = hs && (wr_cnt == '1);
    assign waddr   = RW'(wr_cnt >> LOG2_TP);
    assign we      = hs && (lane == '0);
    assign rd_last = (rd_cnt == RW'(WORDS - 1));
    assign gap_end = (gap_cnt == GW'(GAP - 1));
    assign re      = (state == S_PRIME) || ((state == S_STREAM) && !rd_last);
    assign raddr   = (state == S_PRIME) ? '0 : rd_cnt + RW'(1);

    // Place the incoming sample into its lane; the completed word goes straight
    // to the bank on the same edge as the last lane's handshake
    always_comb begin
        lane           = LW'(lane_of(int'(wr_cnt), THROUGHPUT));
        pack_nxt       = pack;
        pack_nxt[lane] = s_data;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_FILL;
        else     state <= nxt;
    end

    // Next state and burst outputs
    always_comb begin
        nxt        = state;
        vld_out    = 1'b0;
        frame_done = 1'b0;
        case (state)
            S_FILL:   if (frame_rdy) nxt = S_PRIME;
            S_PRIME:  nxt = S_STREAM;
            S_STREAM: begin
                vld_out    = 1'b1;
                frame_done = rd_last;
                if (rd_last) nxt = S_GAP;
            end
            S_GAP:    if (gap_end) nxt = frame_rdy ? S_PRIME : S_FILL;
            default:  nxt = S_FILL;
        endcase
    end

    // Write/read/gap counters and the lane pack register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_cnt  <= '0;
            rd_cnt  <= '0;
            gap_cnt <= '0;
            pack    <= '0;
        end else begin
            if (hs) begin
                wr_cnt <= wr_cnt + 1'b1;
                pack   <= pack_nxt;
            end
            if (state == S_STREAM) rd_cnt  <= rd_last ? '0 : rd_cnt + RW'(1);
            if (state == S_GAP)    gap_cnt <= gap_end ? '0 : gap_cnt + GW'(1);
        end
    end

`ifdef IMG_STREAMER_PINGPONG_EN
    logic          wr_bank, rd_bank, out_sel, rd_free;
    logic [1:0]    full;
    logic [DW-1:0] q0, q1;

    // A bank becomes writable on the cycle its last word is read out
    assign rd_free   = (state == S_STREAM) && rd_last;
    assign s_rdy     = !full[wr_bank] || (rd_free && (rd_bank == wr_bank));
    assign frame_rdy = full[rd_bank] || (last_hs && (wr_bank == rd_bank));
    assign data_out  = out_sel ? q1 : q0;

    // Bank ownership: writer and reader each walk the two banks in order.
    // out_sel follows the reader only when a new burst begins, so the
    // output keeps holding the previous burst's last word until then.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            out_sel <= 1'b0;
            full    <= '0;
        end else begin
            if (rd_free) begin
                full[rd_bank] <= 1'b0;
                rd_bank       <= ~rd_bank;
            end
            if (last_hs) begin
                full[wr_bank] <= 1'b1;
                wr_bank       <= ~wr_bank;
            end
            if (state == S_PRIME) out_sel <= rd_bank;
        end
    end

    frame_bank #(.DW(DW), .DEPTH(WORDS), .AW(RW)) u_bank0 (
        .clk(clk), .rst(rst),
        .we(we && !wr_bank), .waddr(waddr), .wdata(pack_nxt),
        .re(re && !rd_bank), .raddr(raddr), .rdata(q0)
    );

    frame_bank #(.DW(DW), .DEPTH(WORDS), .AW(RW)) u_bank1 (
        .clk(clk), .rst(rst),
        .we(we && wr_bank), .waddr(waddr), .wdata(pack_nxt),
        .re(re && rd_bank), .raddr(raddr), .rdata(q1)
    );
`else
    logic [DW-1:0] q0;

    assign s_rdy     = (state == S_FILL);
    assign frame_rdy = last_hs;
    assign data_out  = q0;

    frame_bank #(.DW(DW), .DEPTH(WORDS), .AW(RW)) u_bank0 (
        .clk(clk), .rst(rst),
        .we(we), .waddr(waddr), .wdata(pack_nxt),
        .re(re), .raddr(raddr), .rdata(q0)
    );
`endif

endmodule

// File: tb/tb_image_streamer.sv
// Directed bench for image_streamer: reset, basic and bursty fills, reset
// mid-burst, single-word image, and (with IMG_STREAMER_PINGPONG_EN) ping-pong.
module tb_image_streamer;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // DUT a: 2 lanes, 8 words
    logic             a_vld = 1'b0, a_rdy, a_vout, a_fd;
    logic [1:0]       a_data = '0;
    logic [1:0][1:0]  a_out;
    // DUT b: 16 lanes, single word
    logic             b_vld = 1'b0, b_rdy, b_vout, b_fd;
    logic [1:0]       b_data = '0;
    logic [15:0][1:0] b_out;

    image_streamer #(.NO_CH(2), .LOG2_IMG_SIZE(4), .THROUGHPUT(2), .GAP(4)) u_a (
        .clk(clk), .rst(rst), .s_vld(a_vld), .s_rdy(a_rdy), .s_data(a_data),
        .vld_out(a_vout), .data_out(a_out), .frame_done(a_fd)
    );

    image_streamer #(.NO_CH(2), .LOG2_IMG_SIZE(4), .THROUGHPUT(16), .GAP(4)) u_b (
        .clk(clk), .rst(rst), .s_vld(b_vld), .s_rdy(b_rdy), .s_data(b_data),
        .vld_out(b_vout), .data_out(b_out), .frame_done(b_fd)
    );

`ifdef IMG_STREAMER_PINGPONG_EN
    logic            c_vld = 1'b0, c_rdy, c_vout, c_fd;
    logic [1:0]      c_data = '0;
    logic [0:0][1:0] c_out;

    image_streamer #(.NO_CH(2), .LOG2_IMG_SIZE(4), .THROUGHPUT(1), .GAP(4)) u_c (
        .clk(clk), .rst(rst), .s_vld(c_vld), .s_rdy(c_rdy), .s_data(c_data),
        .vld_out(c_vout), .data_out(c_out), .frame_done(c_fd)
    );
`endif

    int errs = 0;
    int nchk = 0;

    // Expected words of DUT a: pattern 0 is n mod 4, pattern 1 is (n>>1) mod 4
    logic [3:0] exp_w [2][8] = '{
        '{4'h1, 4'hB, 4'h1, 4'hB, 4'h1, 4'hB, 4'h1, 4'hB},
        '{4'h0, 4'h5, 4'hA, 4'hF, 4'h0, 4'h5, 4'hA, 4'hF}
    };

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nchk++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] pat_val(input int pat, input int n);
        case (pat)
            0:       return 2'(n % 4);
            1:       return 2'((n >> 1) % 4);
            default: return 2'((n >> 2) % 4);
        endcase
    endfunction

    // Push 16 samples into DUT a (which=0) or b (which=1); returns just after
    // the edge that captured the last one
    task automatic feed(input int which, input int duty, input int pat);
        int   n = 0;
        int   guard = 0;
        logic v, hs;
        while (n < 16 && guard < 1000) begin
            v = ($urandom_range(0, 99) < duty);
            if (which == 0) begin a_vld = v; a_data = pat_val(pat, n); end
            else            begin b_vld = v; b_data = pat_val(pat, n); end
            @(negedge clk);
            hs = v && ((which == 0) ? a_rdy : b_rdy);
            step();
            if (hs) n++;
            guard++;
        end
        a_vld = 1'b0;
        b_vld = 1'b0;
        chk("feed_count", n, 16);
    endtask

    // Follow DUT a from PRIME through the burst and gap back to FILL
    task automatic burst_a(input int pat);
        chk("a_prime_vld", a_vout, 0);
`ifndef IMG_STREAMER_PINGPONG_EN
        chk("a_prime_rdy", a_rdy, 0);
`endif
        for (int k = 0; k < 8; k++) begin
            step();
            chk("a_vld", a_vout, 1);
            chk("a_data", a_out, exp_w[pat][k]);
            chk("a_done", a_fd, (k == 7));
        end
        for (int g = 0; g < 4; g++) begin
            step();
            chk("a_gap_vld", a_vout, 0);
            chk("a_gap_done", a_fd, 0);
            chk("a_hold", a_out, exp_w[pat][7]);
`ifndef IMG_STREAMER_PINGPONG_EN
            chk("a_gap_rdy", a_rdy, 0);
`endif
        end
        step();
        chk("a_rdy_back", a_rdy, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 rst = 1'b1;
        #1;
        chk("rst_a_rdy", a_rdy, 1);
        chk("rst_a_vld", a_vout, 0);
        chk("rst_a_done", a_fd, 0);
        chk("rst_a_data", a_out, 0);
        chk("rst_b_rdy", b_rdy, 1);
        chk("rst_b_data", b_out, 0);
        @(negedge clk);
        rst = 1'b0;
        step();

        // Basic and bursty fills must produce the same contiguous burst
        feed(0, 100, 0);
        burst_a(0);
        feed(0, 30, 0);
        burst_a(0);

        // Reset asserted between edges during the third STREAM cycle
        feed(0, 100, 0);
        step(); step(); step();
        chk("mid_vld", a_vout, 1);
        chk("mid_data", a_out, exp_w[0][2]);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_vld", a_vout, 0);
        chk("mid_rst_done", a_fd, 0);
        chk("mid_rst_data", a_out, 0);
        chk("mid_rst_rdy", a_rdy, 1);
        @(negedge clk);
        rst = 1'b0;
        step();
        feed(0, 100, 1);
        burst_a(1);

        // Whole image in one word: single-cycle burst, lane 15 holds sample 0
        feed(1, 100, 2);
        chk("b_prime_vld", b_vout, 0);
        step();
        chk("b_vld", b_vout, 1);
        chk("b_done", b_fd, 1);
        chk("b_data", b_out, 32'h0055AAFF);
        step();
        chk("b_gap_vld", b_vout, 0);
        chk("b_gap_done", b_fd, 0);
        chk("b_hold", b_out, 32'h0055AAFF);
        step(); step(); step();
`ifndef IMG_STREAMER_PINGPONG_EN
        chk("b_gap_rdy", b_rdy, 0);
`endif
        step();
        chk("b_rdy_back", b_rdy, 1);

`ifdef IMG_STREAMER_PINGPONG_EN
        // Three back-to-back frames; sample n of frame f carries (n+f) mod 4
        fork
            begin
                for (int i = 0; i < 48; i++) begin
                    c_vld  = 1'b1;
                    c_data = 2'(((i % 16) + (i / 16)) % 4);
                    @(negedge clk);
                    chk("pp_rdy", c_rdy, 1);
                    step();
                end
                c_vld = 1'b0;
            end
            begin
                int idle = 0;
                int got  = 0;
                bit started = 1'b0;
                for (int cyc = 0; cyc < 300 && got < 48; cyc++) begin
                    @(negedge clk);
                    if (c_vout) begin
                        if (started) chk("pp_idle", idle, ((got % 16) == 0) ? 5 : 0);
                        chk("pp_data", c_out, ((got % 16) + (got / 16)) % 4);
                        chk("pp_done", c_fd, ((got % 16) == 15));
                        got++;
                        started = 1'b1;
                        idle = 0;
                    end else begin
                        idle++;
                    end
                end
                chk("pp_count", got, 48);
            end
        join
`endif

        $display("Result: errors=%0d of %0d checks", errs, nchk);
        $finish;
    end

endmodule
